updown_mod: RTL and testbench
=============================

UPDOWN_MOD -- requirements
Module: updown_mod

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the count width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 16, the count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-004 The block SHALL have a port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have a port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have a port load, input, 1 bit: synchronous parallel load of data_in.
REQ-007 The block SHALL have a port data_in, input, WIDTH bits: the load value.
REQ-008 The block SHALL have a port control, input, 1 bit: direction, 1 = up, 0 = down.
REQ-009 The block SHALL have a port enable, input, 1 bit: count step enable.
REQ-010 The block SHALL have a port clr_ovf, input, 1 bit: synchronous clear of the ovf flag.
REQ-011 The block SHALL have a port count, output, WIDTH bits, registered: the current count.
REQ-012 The block SHALL have a port tc, output, 1 bit, registered: a one-cycle pulse on a limit event.
REQ-013 The block SHALL have a port ovf, output, 1 bit, registered: a sticky limit-event flag.

Function
REQ-014 The block SHALL apply per-edge priority in this order: load, then enable, then hold.
REQ-015 When load=1, count SHALL take data_in on the next edge; if data_in >= MODULUS, count SHALL take MODULUS-1 (clamp); tc SHALL be 0 for that cycle.
REQ-016 When load=0, enable=1, control=1 and count < MODULUS-1, count SHALL increment by 1.
REQ-017 When load=0, enable=1, control=0 and count > 0, count SHALL decrement by 1.
REQ-018 An up step at count = MODULUS-1 SHALL be a limit event; count SHALL go to 0 (SATURATE=0) or stay at MODULUS-1 (SATURATE=1).
REQ-019 A down step at count = 0 SHALL be a limit event; count SHALL go to MODULUS-1 (SATURATE=0) or stay at 0 (SATURATE=1).
REQ-020 tc SHALL be 1 for exactly the cycle following the edge that processes a limit event, and 0 otherwise.
REQ-021 With SATURATE=1, repeated steps into a limit SHALL produce a tc pulse on each such edge.
REQ-022 ovf SHALL set on any limit event and remain set until clr_ovf=1.
REQ-023 If clr_ovf=1 and a limit event occur on the same edge, ovf SHALL be 1 (set wins).
REQ-024 When enable=0 and load=0, count SHALL hold and tc SHALL be 0.
REQ-025 Step latency SHALL be one clock: a step processed at edge N is visible on count after edge N.
REQ-026 Arithmetic SHALL be done in WIDTH bits with no intermediate overflow; with MODULUS = 2**WIDTH, wrap SHALL equal natural binary rollover.
REQ-027 count SHALL never leave 0..MODULUS-1 after reset.

Reset
REQ-028 On rst=1, count, tc and ovf SHALL go to 0 immediately, independent of clk.
REQ-029 rst asserted mid-count SHALL discard any pending load or step; the first edge after deassertion SHALL process inputs normally.

Structure
REQ-030 A shared package updown_pkg SHALL hold the mode constants MODE_WRAP=0 and MODE_SAT=1 and the direction constants DIR_UP=1 and DIR_DOWN=0.
REQ-031 Next-count and limit-event logic SHALL live in one combinational sub-module, updown_next; updown_mod SHALL hold the registers only.
REQ-032 Illegal MODULUS values SHALL be rejected at elaboration.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-033 The bench SHALL check load and wrap up: load 8, control=1, enable=1 -> count 8, 9, 0 with tc=1 for the cycle after 9 -> 0, and ovf=1.
REQ-034 The bench SHALL check wrap down: load 1, control=0 -> count 1, 0, 9, 8 with a single tc pulse.
REQ-035 The bench SHALL check saturation with SATURATE=1: load 0, control=0, enable=1 for 3 cycles -> count holds at 0, tc=1 on each of those 3 cycles, ovf=1.
REQ-036 The bench SHALL check clamp and priority: load=1, enable=1, data_in=13 -> count=9 and tc=0; then clr_ovf -> ovf=0.
REQ-037 The bench SHALL check asynchronous reset: count at 5, assert rst between edges -> count=0, tc=0 and ovf=0 before the next edge; deassert rst with control=1 -> count 1 on the following edge.
REQ-038 The bench SHALL check full binary range with MODULUS=16: count up from 15 -> 0 with tc=1, matching natural rollover.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared constants for the up/down modulo counter: saturation modes and count directions.
package updown_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_next.sv
// Combinational next-count and limit-event logic for updown_mod.
module updown_next
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             control,
  input  logic             enable,
  output logic [WIDTH-1:0] count_nxt,
  output logic             limit
);

  // MODULUS-1 always fits in WIDTH bits, so the clamp compare never overflows.
  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);
  localparam bit               Sat      = (SATURATE == MODE_SAT);

  always_comb begin
    count_nxt = count;
    limit     = 1'b0;
    if (load) begin
      count_nxt = (data_in > MaxCount) ? MaxCount : data_in;
    end else if (enable) begin
      if (control == DIR_UP) begin
        if (count == MaxCount) begin
          limit     = 1'b1;
          count_nxt = Sat ? MaxCount : '0;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          limit     = 1'b1;
          count_nxt = Sat ? '0 : MaxCount;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/updown_mod.sv
// Up/down modulo counter with load, wrap or saturate at limits, tc pulse and sticky ovf flag.
module updown_mod
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             control,
  input  logic             enable,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : gen_bad_modulus
    $fatal(1, "updown_mod: MODULUS must lie in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, ovf_q, limit;

  updown_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .count    (count_q),
    .load     (load),
    .data_in  (data_in),
    .control  (control),
    .enable   (enable),
    .count_nxt(count_d),
    .limit    (limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= limit;
      // A limit event on the same edge as clr_ovf keeps the flag set.
      ovf_q   <= limit | (ovf_q & ~clr_ovf);
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_mod.sv
// Randomized and directed bench for updown_mod: three instances checked against a modulo-arithmetic model.
module tb_updown_mod;
  import updown_pkg::*;

  localparam int NI = 3;  // 0: mod 10 wrap, 1: mod 10 saturate, 2: mod 16 wrap

  logic       clk, rst, load, control, enable, clr_ovf;
  logic [3:0] data_in;
  logic [3:0] cnt [NI];
  logic       tc_o [NI];
  logic       ovf_o [NI];

  int m_cnt [NI];
  bit m_tc  [NI];
  bit m_ovf [NI];

  int n_checks = 0;
  int n_fail   = 0;

  updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(MODE_WRAP)) u_wrap10 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .control(control),
    .enable(enable), .clr_ovf(clr_ovf), .count(cnt[0]), .tc(tc_o[0]), .ovf(ovf_o[0])
  );
  updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(MODE_SAT)) u_sat10 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .control(control),
    .enable(enable), .clr_ovf(clr_ovf), .count(cnt[1]), .tc(tc_o[1]), .ovf(ovf_o[1])
  );
  updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(MODE_WRAP)) u_wrap16 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .control(control),
    .enable(enable), .clr_ovf(clr_ovf), .count(cnt[2]), .tc(tc_o[2]), .ovf(ovf_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mod_of(input int i);
    return (i == 2) ? 16 : 10;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0;
      m_tc[i]  = 1'b0;
      m_ovf[i] = 1'b0;
    end
  endtask

  // One clock edge of the reference: modulo arithmetic, limits detected by value.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int m  = mod_of(i);
      bit ev = 1'b0;
      if (load) begin
        m_cnt[i] = (int'(data_in) >= m) ? m - 1 : int'(data_in);
      end else if (enable) begin
        ev = control ? (m_cnt[i] == m - 1) : (m_cnt[i] == 0);
        if (!(ev && i == 1)) m_cnt[i] = (m_cnt[i] + (control ? 1 : m - 1)) % m;
      end
      m_tc[i]  = ev;
      m_ovf[i] = ev || (m_ovf[i] && !clr_ovf);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s[%0d].count", tag, i), 32'(cnt[i]), 32'(m_cnt[i]));
      check($sformatf("%s[%0d].tc", tag, i), 32'(tc_o[i]), 32'(m_tc[i]));
      check($sformatf("%s[%0d].ovf", tag, i), 32'(ovf_o[i]), 32'(m_ovf[i]));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Called 1 time unit after an edge: pulse rst between edges and expect an immediate clear.
  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s[%0d].count", tag, i), 32'(cnt[i]), 0);
      check($sformatf("%s[%0d].tc", tag, i), 32'(tc_o[i]), 0);
      check($sformatf("%s[%0d].ovf", tag, i), 32'(ovf_o[i]), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = '0; control = 1'b0; enable = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Load then wrap up on the mod-10 instance.
    load = 1'b1; data_in = 4'd8;
    step("ld8");
    check("wrap_up.ld", 32'(cnt[0]), 8);
    load = 1'b0; enable = 1'b1; control = DIR_UP;
    step("up1");
    check("wrap_up.9", 32'(cnt[0]), 9);
    check("wrap_up.tc9", 32'(tc_o[0]), 0);
    step("up2");
    check("wrap_up.0", 32'(cnt[0]), 0);
    check("wrap_up.tc", 32'(tc_o[0]), 1);
    check("wrap_up.ovf", 32'(ovf_o[0]), 1);

    // Wrap down: 1, 0, 9, 8 with one tc pulse.
    enable = 1'b0; clr_ovf = 1'b1;
    step("clr1");
    clr_ovf = 1'b0; load = 1'b1; data_in = 4'd1;
    step("ld1");
    check("wrap_dn.1", 32'(cnt[0]), 1);
    load = 1'b0; enable = 1'b1; control = DIR_DOWN;
    step("dn1");
    check("wrap_dn.0", 32'(cnt[0]), 0);
    check("wrap_dn.tc0", 32'(tc_o[0]), 0);
    step("dn2");
    check("wrap_dn.9", 32'(cnt[0]), 9);
    check("wrap_dn.tc9", 32'(tc_o[0]), 1);
    step("dn3");
    check("wrap_dn.8", 32'(cnt[0]), 8);
    check("wrap_dn.tc8", 32'(tc_o[0]), 0);

    // Saturation: three down steps at 0 each pulse tc.
    enable = 1'b0; load = 1'b1; data_in = 4'd0;
    step("ld0");
    load = 1'b0; enable = 1'b1; control = DIR_DOWN;
    for (int k = 0; k < 3; k++) begin
      step("sat");
      check($sformatf("sat.count%0d", k), 32'(cnt[1]), 0);
      check($sformatf("sat.tc%0d", k), 32'(tc_o[1]), 1);
    end
    check("sat.ovf", 32'(ovf_o[1]), 1);

    // Clamp with load beating enable, then clear ovf.
    load = 1'b1; data_in = 4'd13;
    step("clamp");
    check("clamp.count", 32'(cnt[0]), 9);
    check("clamp.tc", 32'(tc_o[0]), 0);
    check("clamp.count16", 32'(cnt[2]), 13);
    load = 1'b0; enable = 1'b0; clr_ovf = 1'b1;
    step("clr2");
    check("clr.ovf", 32'(ovf_o[0]), 0);
    clr_ovf = 1'b0;

    // Asynchronous reset mid-count, then resume upward.
    load = 1'b1; data_in = 4'd5;
    step("ld5");
    check("arst.pre", 32'(cnt[0]), 5);
    enable = 1'b1; control = DIR_UP;  // pending load/step must be discarded
    async_reset("arst");
    load = 1'b0;
    step("arst.resume");
    check("arst.count1", 32'(cnt[0]), 1);

    // Full binary range on the mod-16 instance.
    load = 1'b1; enable = 1'b0; data_in = 4'd15;
    step("ld15");
    load = 1'b0; enable = 1'b1; control = DIR_UP;
    step("roll");
    check("roll16.count", 32'(cnt[2]), 0);
    check("roll16.tc", 32'(tc_o[2]), 1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      load    = ($urandom_range(0, 7) == 0);
      data_in = 4'($urandom_range(0, 15));
      control = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) async_reset("rnd.arst");
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
